// File: rtl/vericlock_pkg.sv
// Shared definitions for the clock/calendar setting logic: field encoding,
// digit blink masks and small helpers used by the edit controller.
package vericlock_pkg;

  localparam logic [2:0] ST_RUN  = 3'd0;
  localparam logic [2:0] ST_HOUR = 3'd1;
  localparam logic [2:0] ST_MIN  = 3'd2;
  localparam logic [2:0] ST_SEC  = 3'd3;
  localparam logic [2:0] ST_DAY  = 3'd4;
  localparam logic [2:0] ST_MON  = 3'd5;
  localparam logic [2:0] ST_YEAR = 3'd6;

  localparam logic [7:0] MASK_HOUR_DAY = 8'h03;
  localparam logic [7:0] MASK_MIN_MON  = 8'h0C;
  localparam logic [7:0] MASK_SEC      = 8'h30;
  localparam logic [7:0] MASK_YEAR     = 8'hC0;

  typedef enum logic [2:0] {
    RUN    = ST_RUN,
    E_HOUR = ST_HOUR,
    E_MIN  = ST_MIN,
    E_SEC  = ST_SEC,
    E_DAY  = ST_DAY,
    E_MON  = ST_MON,
    E_YEAR = ST_YEAR
  } state_t;

  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] field_mask(input state_t s);
    case (s)
      E_HOUR, E_DAY: return MASK_HOUR_DAY;
      E_MIN, E_MON:  return MASK_MIN_MON;
      E_SEC:         return MASK_SEC;
      E_YEAR:        return MASK_YEAR;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic is_time_field(input state_t s);
    return (s == E_HOUR) || (s == E_MIN) || (s == E_SEC);
  endfunction

  function automatic state_t advance(input state_t s);
    case (s)
      RUN:     return E_HOUR;
      E_HOUR:  return E_MIN;
      E_MIN:   return E_SEC;
      E_SEC:   return E_DAY;
      E_DAY:   return E_MON;
      E_MON:   return E_YEAR;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the debouncers/timer, the edit controller and the
// clock, calendar and display blocks.
interface clock_set_ctrl_if;
  import vericlock_pkg::*;

  // Handshake: there is no valid/ready pair here. Every strobe (tick_*, inc_*)
  // is a single-cycle pulse with no backpressure; levels (btn_*, page_sel) are
  // sampled every cycle and outputs are registered.
  logic       btn_mode;
  logic       btn_inc;
  logic       page_sel;
  logic       tick_1Hz_in;
  logic       tick_1Hz_out;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       inc_day;
  logic       inc_month;
  logic       inc_year;
  logic       page_datetime;
  logic [7:0] blink_mask;
  logic       editing;
  logic [2:0] field;
  rep_state_t repeat_state;

  modport slave (
    input  btn_mode, btn_inc, page_sel, tick_1Hz_in,
    output tick_1Hz_out, inc_hour, inc_min, inc_sec, inc_day, inc_month,
           inc_year, page_datetime, blink_mask, editing, field, repeat_state
  );

  modport master (
    output btn_mode, btn_inc, page_sel, tick_1Hz_in,
    input  tick_1Hz_out, inc_hour, inc_min, inc_sec, inc_day, inc_month,
           inc_year, page_datetime, blink_mask, editing, field, repeat_state
  );

endinterface

// File: rtl/btn_autorepeat.sv
// Rising-edge detector with hold-to-repeat: one pulse on press, then a pulse
// after DELAY_CYC cycles and every RATE_CYC cycles while the button stays down.
module btn_autorepeat
  import vericlock_pkg::*;
#(
  parameter int unsigned DELAY_CYC = 50_000_000,
  parameter int unsigned RATE_CYC  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       enable,
  input  logic       clear,
  output logic       rise,
  output logic       pulse,
  output rep_state_t rep_state
);

  localparam int CNT_W = cnt_width((DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);

  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  rep_state_t       state_next;

  // Kept outside the next-state block so the parent can use it to build clear.
  assign rise = btn & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= 1'b0;
      rep_state <= REP_IDLE;
      cnt       <= '0;
    end else begin
      btn_q     <= btn;
      rep_state <= state_next;
      cnt       <= cnt_next;
    end
  end

  always_comb begin
    pulse      = 1'b0;
    state_next = rep_state;
    cnt_next   = cnt;
    if (clear || !enable || !btn) begin
      state_next = REP_IDLE;
      cnt_next   = '0;
    end else if (rise) begin
      pulse      = 1'b1;
      state_next = REP_DELAY;
      cnt_next   = '0;
    end else begin
      case (rep_state)
        REP_DELAY: begin
          if (cnt == DELAY_LAST) begin
            pulse      = 1'b1;
            state_next = REP_RATE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        REP_RATE: begin
          if (cnt == RATE_LAST) begin
            pulse    = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          // A button still held from before a clear never restarts repeating.
          state_next = REP_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit-mode controller: steps through the time/date fields on mode presses,
// issues field increment pulses, freezes time while edited, drives blink/page.
module clock_set_ctrl
  import vericlock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter int unsigned BLINK_HALF_CYC   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC      = 1_000_000_000
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  clock_set_ctrl_if.slave   bus
);

  localparam int BLINK_W = cnt_width(BLINK_HALF_CYC);
  localparam int IDLE_W  = cnt_width(TIMEOUT_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

  state_t             state;
  state_t             state_next;
  logic               btn_mode_q;
  logic               mode_rise;
  logic               in_edit;
  logic               inc_rise;
  logic               inc_pulse;
  logic               timeout_hit;
  logic               rep_clear;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [IDLE_W-1:0]  idle_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic               blink_phase;
  logic               blink_phase_next;

  assign mode_rise = bus.btn_mode & ~btn_mode_q;
  assign in_edit   = (state != RUN);
  // An inc press counts as activity, so it beats an expiring idle count.
  assign timeout_hit = in_edit && !mode_rise && !inc_rise && (idle_cnt == IDLE_LAST);
  assign rep_clear   = mode_rise | timeout_hit;
  assign bus.field   = state;

  btn_autorepeat #(
    .DELAY_CYC (REPEAT_DELAY_CYC),
    .RATE_CYC  (REPEAT_RATE_CYC)
  ) u_inc_rep (
    .clk       (clk_100MHz),
    .rst       (reset),
    .btn       (bus.btn_inc),
    .enable    (in_edit),
    .clear     (rep_clear),
    .rise      (inc_rise),
    .pulse     (inc_pulse),
    .rep_state (bus.repeat_state)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      btn_mode_q  <= 1'b0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_next;
      btn_mode_q  <= bus.btn_mode;
      idle_cnt    <= idle_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
    end
  end

  always_comb begin : fsm_next
    state_next = state;
    if (mode_rise) begin
      state_next = advance(state);
    end else if (timeout_hit) begin
      state_next = RUN;
    end
  end

  // Idle and blink counters restart on every field change and rest in RUN.
  always_comb begin : counters_next
    idle_next        = '0;
    blink_cnt_next   = '0;
    blink_phase_next = 1'b0;
    if (in_edit && (state_next == state)) begin
      if (!(inc_rise || inc_pulse)) begin
        idle_next = idle_cnt + IDLE_W'(1);
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next   = blink_cnt + BLINK_W'(1);
        blink_phase_next = blink_phase;
      end
    end
  end

  // Outputs follow the field being entered so they switch together with field.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      bus.tick_1Hz_out  <= 1'b0;
      bus.page_datetime <= 1'b1;
      bus.editing       <= 1'b0;
      bus.blink_mask    <= 8'h00;
      bus.inc_hour      <= 1'b0;
      bus.inc_min       <= 1'b0;
      bus.inc_sec       <= 1'b0;
      bus.inc_day       <= 1'b0;
      bus.inc_month     <= 1'b0;
      bus.inc_year      <= 1'b0;
    end else begin
      bus.tick_1Hz_out  <= bus.tick_1Hz_in & ~is_time_field(state_next);
      bus.page_datetime <= (state_next == RUN) ? bus.page_sel : is_time_field(state_next);
      bus.editing       <= (state_next != RUN);
      bus.blink_mask    <= ((state_next != RUN) && blink_phase_next && !bus.btn_inc)
                           ? field_mask(state_next) : 8'h00;
      bus.inc_hour      <= inc_pulse && (state == E_HOUR);
      bus.inc_min       <= inc_pulse && (state == E_MIN);
      bus.inc_sec       <= inc_pulse && (state == E_SEC);
      bus.inc_day       <= inc_pulse && (state == E_DAY);
      bus.inc_month     <= inc_pulse && (state == E_MON);
      bus.inc_year      <= inc_pulse && (state == E_YEAR);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: scripted scenarios plus random button activity,
// checked cycle by cycle against a reference model through an expected queue.
module tb_clock_set_ctrl;
  import vericlock_pkg::*;

  localparam int DLY  = 8;
  localparam int RATE = 4;
  localparam int HALF = 5;
  localparam int TO   = 50;
  localparam int W    = 20;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .REPEAT_DELAY_CYC (DLY),
    .REPEAT_RATE_CYC  (RATE),
    .BLINK_HALF_CYC   (HALF),
    .TIMEOUT_CYC      (TO)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int m_field;
  int m_hold;
  int m_since;
  int m_age;
  bit m_mode_prev;
  bit m_inc_prev;
  bit cur_psel;
  int cyc = 0;

  function automatic logic [W-1:0] pack_vec(input int fld, input bit ed, input bit pg,
                                             input logic [7:0] mk, input bit tk,
                                             input logic [5:0] incs);
    return {3'(fld), ed, pg, mk, tk, incs};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {bus.field, bus.editing, bus.page_datetime, bus.blink_mask, bus.tick_1Hz_out,
            bus.inc_year, bus.inc_month, bus.inc_day, bus.inc_sec, bus.inc_min, bus.inc_hour};
  endfunction

  function automatic logic [7:0] mask_of(input int f);
    case (f)
      1, 4:    return 8'h03;
      2, 5:    return 8'h0C;
      3:       return 8'h30;
      6:       return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_field     = 0;
    m_hold      = 0;
    m_since     = 0;
    m_age       = 0;
    m_mode_prev = 1'b0;
    m_inc_prev  = 1'b0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input bit mode, input bit inc, input bit psel, input bit tick);
    bit mode_rise, inc_rise, tk, pg;
    int nxt, pf;
    logic [7:0] mk;
    logic [5:0] incs;
    @(negedge clk);
    bus.btn_mode    = mode;
    bus.btn_inc     = inc;
    bus.page_sel    = psel;
    bus.tick_1Hz_in = tick;
    mode_rise = mode && !m_mode_prev;
    inc_rise  = inc && !m_inc_prev;
    nxt = m_field;
    pf  = 0;
    if (m_field == 0) begin
      if (mode_rise) nxt = 1;
      m_hold  = 0;
      m_since = 0;
    end else if (mode_rise) begin
      nxt    = (m_field == 6) ? 0 : m_field + 1;
      m_hold = 0;
    end else if (!inc_rise && m_since == TO - 1) begin
      nxt    = 0;
      m_hold = 0;
    end else begin
      if (inc_rise) begin
        m_hold = 1;
        pf     = m_field;
      end else if (inc && m_hold > 0) begin
        m_hold++;
        if (m_hold >= DLY + 1 && (m_hold - 1 - DLY) % RATE == 0) pf = m_field;
      end else begin
        m_hold = 0;
      end
      if (inc_rise || pf != 0) m_since = 0;
      else m_since++;
    end
    if (nxt != m_field) begin
      m_age   = 0;
      m_since = 0;
    end else begin
      m_age++;
    end
    incs = (pf != 0) ? 6'(1 << (pf - 1)) : 6'd0;
    tk   = tick && !(nxt >= 1 && nxt <= 3);
    pg   = (nxt == 0) ? psel : (nxt <= 3);
    mk   = (nxt != 0 && ((m_age / HALF) % 2 == 1) && !inc) ? mask_of(nxt) : 8'h00;
    exp_q.push_back(pack_vec(nxt, nxt != 0, pg, mk, tk, incs));
    m_field     = nxt;
    m_mode_prev = mode;
    m_inc_prev  = inc;
  endtask

  task automatic run(input int n, input bit mode, input bit inc);
    repeat (n) begin
      step(mode, inc, cur_psel, (cyc % 10) == 0);
      cyc++;
    end
  endtask

  task automatic press_mode(input int n);
    repeat (n) begin
      run(2, 1'b1, 1'b0);
      run(3, 1'b0, 1'b0);
    end
  endtask

  // monitor: compares every registered output set the DUT presents
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) check("outputs", dut_vec(), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    bit r_mode, r_inc;
    bus.btn_mode    = 1'b0;
    bus.btn_inc     = 1'b0;
    bus.page_sel    = 1'b0;
    bus.tick_1Hz_in = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #3;
    check("reset_outputs", dut_vec(), pack_vec(0, 0, 1, 8'h00, 0, 6'd0));
    check("reset_repeat_state", W'(bus.repeat_state), W'(REP_IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // mode cycling through all fields and back to RUN
    cur_psel = 1'b1;
    press_mode(7);
    run(5, 1'b0, 1'b0);

    // auto-repeat in E_MIN, then back to RUN
    press_mode(2);
    run(20, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);
    press_mode(5);

    // tick gating in RUN, E_SEC and E_DAY
    cur_psel = 1'b0;
    run(30, 1'b0, 1'b0);
    press_mode(3);
    run(30, 1'b0, 1'b0);
    press_mode(1);
    run(30, 1'b0, 1'b0);
    press_mode(3);

    // simultaneous mode and inc rise in E_HOUR, then timeout
    press_mode(1);
    run(2, 1'b1, 1'b1);
    run(20, 1'b0, 1'b1);
    run(60, 1'b0, 1'b0);

    // blink and timeout in E_YEAR
    cur_psel = 1'b1;
    press_mode(6);
    run(60, 1'b0, 1'b0);

    // async reset while repeating in E_DAY
    press_mode(4);
    run(12, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset", dut_vec(), pack_vec(0, 0, 1, 8'h00, 0, 6'd0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(10, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);

    // random button activity
    r_mode = 1'b0;
    r_inc  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 9) == 0) r_inc = ~r_inc;
      if ($urandom_range(0, 20) == 0) cur_psel = ~cur_psel;
      step(r_mode, r_inc, cur_psel, $urandom_range(0, 7) == 0);
      cyc++;
    end
    run(3, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
